mempool_remote_link_arbiter: RTL

- Shares one inter-group remote TCDM link between NumIn tile-side requesters.
- Round-robin request arbitration with grant lock until the link accepts.
- Credit-based limit on outstanding transactions.
- In-order response steering back to the issuing requester through an index FIFO.
- Sits between a group's tile masters and one remote request/response channel pair at the cluster level.

---
 rtl/mempool_remote_link_arbiter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mempool_remote_link_arbiter.sv
// mempool_remote_link_arbiter
// Shares one remote TCDM request/response link between NumIn requesters.
// Requests: round-robin arbitration, grant held until the link accepts,
// credit-limited outstanding count. Responses: steered in order back to the
// issuing requester through an index FIFO of depth MaxOutstanding.
// Optional build macro MEMPOOL_REMOTE_LINK_ARB_PERF_EN adds saturating grant
// and stall counters; without it the perf outputs are tied to zero.
module mempool_remote_link_arbiter #(
   parameter int unsigned NumIn          = 4,
   parameter int unsigned ReqWidth       = 64,
   parameter int unsigned RespWidth      = 40,
   parameter int unsigned MaxOutstanding = 8,
   parameter int unsigned IdxW           = $clog2(NumIn)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NumIn*ReqWidth-1:0]            req_i,
   input  logic [NumIn-1:0]                     req_valid_i,
   output logic [NumIn-1:0]                     req_ready_o,
   output logic [NumIn*RespWidth-1:0]           resp_o,
   output logic [NumIn-1:0]                     resp_valid_o,
   input  logic [NumIn-1:0]                     resp_ready_i,
   output logic [ReqWidth-1:0]                  mst_req_o,
   output logic                                 mst_req_valid_o,
   input  logic                                 mst_req_ready_i,
   input  logic [RespWidth-1:0]                 mst_resp_i,
   input  logic                                 mst_resp_valid_i,
   output logic                                 mst_resp_ready_o,
   output logic [$clog2(MaxOutstanding+1)-1:0]  credits_o,
   output logic                                 err_o,
   output logic [31:0]                          perf_grants_o,
   output logic [31:0]                          perf_stalls_o
);

   localparam int unsigned CredW = $clog2(MaxOutstanding + 1);
   localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [CredW-1:0] MaxCred = CredW'(MaxOutstanding);
   localparam logic [PtrW-1:0]  LastPtr = PtrW'(MaxOutstanding - 1);
   localparam logic [IdxW-1:0]  LastIdx = IdxW'(NumIn - 1);

   // Arbitration state
   logic            lock_q, lock_d;
   logic [IdxW-1:0] lock_idx_q, lock_idx_d;
   logic [IdxW-1:0] rr_q, rr_d;

   // Credit and index FIFO state (occupancy mirrors MaxOutstanding - credits)
   logic [CredW-1:0] credits_q, credits_d;
   logic [CredW-1:0] cnt_q, cnt_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [IdxW-1:0]  fifo_q [MaxOutstanding];
   logic [IdxW-1:0]  fifo_d [MaxOutstanding];
   logic             err_q, err_d;

   // Combinational datapath signals
   logic [ReqWidth-1:0] req_pl [NumIn];
   logic                gnt_found;
   logic [IdxW-1:0]     gnt_idx;
   logic [IdxW-1:0]     cand;
   logic                fifo_full, fifo_empty;
   logic                req_hs, resp_hs, resp_drop;
   logic [IdxW-1:0]     head;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   for (genvar g = 0; g < NumIn; g++) begin : g_unpack
      assign req_pl[g] = req_i[g*ReqWidth +: ReqWidth];
   end

   // The link response payload is broadcast; only the valid is steered.
   assign resp_o     = {NumIn{mst_resp_i}};
   assign fifo_full  = (cnt_q == MaxCred);
   assign fifo_empty = (cnt_q == '0);
   assign head       = fifo_q[rd_ptr_q];
   assign credits_o  = credits_q;
   assign err_o      = err_q;

   // Grant selection: locked index wins, else first valid from rr pointer upward
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      if (lock_q) begin
         gnt_found = 1'b1;
         gnt_idx   = lock_idx_q;
      end else begin
         for (int i = 0; i < NumIn; i++) begin
            cand = IdxW'((int'(rr_q) + i) % NumIn);
            if (!gnt_found && req_valid_i[cand]) begin
               gnt_found = 1'b1;
               gnt_idx   = cand;
            end
         end
      end
   end

   // Request issue: valid is independent of the link ready; held low in reset
   always_comb begin
      mst_req_valid_o = rst_ni & gnt_found & (credits_q != '0) & ~fifo_full;
      mst_req_o       = req_pl[gnt_idx];
      req_hs          = mst_req_valid_o & mst_req_ready_i;
      req_ready_o     = '0;
      req_ready_o[gnt_idx] = req_hs;
   end

   // Response steering to the FIFO head; responses with nothing outstanding are dropped
   always_comb begin
      resp_valid_o     = '0;
      mst_resp_ready_o = 1'b0;
      if (rst_ni) begin
         if (fifo_empty) begin
            mst_resp_ready_o = 1'b1;
         end else begin
            resp_valid_o[head] = mst_resp_valid_i;
            mst_resp_ready_o   = resp_ready_i[head];
         end
      end
      resp_hs   = mst_resp_valid_i & mst_resp_ready_o & ~fifo_empty;
      resp_drop = rst_ni & mst_resp_valid_i & fifo_empty;
   end

   // Next-state for lock, round-robin pointer, credits, FIFO and error flag
   always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      rr_d       = rr_q;
      credits_d  = credits_q;
      cnt_d      = cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_d     = fifo_q;
      err_d      = err_q | resp_drop;

      if (req_hs) begin
         lock_d           = 1'b0;
         rr_d             = (gnt_idx == LastIdx) ? '0 : gnt_idx + IdxW'(1);
         fifo_d[wr_ptr_q] = gnt_idx;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end else if (mst_req_valid_o) begin
         lock_d     = 1'b1;
         lock_idx_d = gnt_idx;
      end

      if (resp_hs) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      // A simultaneous push and pop leaves credits and occupancy untouched.
      if (req_hs && !resp_hs) begin
         credits_d = credits_q - CredW'(1);
         cnt_d     = cnt_q + CredW'(1);
      end else if (resp_hs && !req_hs) begin
         credits_d = credits_q + CredW'(1);
         cnt_d     = cnt_q - CredW'(1);
      end
   end

   // Control state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         rr_q       <= '0;
         credits_q  <= MaxCred;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         rr_q       <= rr_d;
         credits_q  <= credits_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         err_q      <= err_d;
      end
   end

   // FIFO storage; entries are only read while valid, so no reset is needed
   always_ff @(posedge clk_i) begin
      fifo_q <= fifo_d;
   end

`ifdef MEMPOOL_REMOTE_LINK_ARB_PERF_EN
   logic [31:0] perf_grants_q, perf_grants_d;
   logic [31:0] perf_stalls_q, perf_stalls_d;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Count issued requests and cycles where someone waits without an issue
   always_comb begin
      perf_grants_d = perf_grants_q;
      perf_stalls_d = perf_stalls_q;
      if (req_hs) begin
         perf_grants_d = sat_inc(perf_grants_q);
      end else if (|req_valid_i) begin
         perf_stalls_d = sat_inc(perf_stalls_q);
      end
   end

   // Performance counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_grants_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         perf_grants_q <= perf_grants_d;
         perf_stalls_q <= perf_stalls_d;
      end
   end

   assign perf_grants_o = perf_grants_q;
   assign perf_stalls_o = perf_stalls_q;
`else
   assign perf_grants_o = '0;
   assign perf_stalls_o = '0;
`endif

endmodule
